// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller: stall, flush, redirect, bubbles, freeze, HALT drain.
// Latency: control outputs are combinational (same cycle); halted/state/counters are registered.
// Backpressure: mem_busy freezes the whole pipe (stall=1) and holds the FSM until released.
module pipeline_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES      = 3,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic       load_use,
  input  logic       ex_branch_taken,
  input  logic [7:0] ex_branch_target,
  input  logic       mem_busy,
  input  logic       halt_fetched,
  output logic       stall,
  output logic       flush,
  output logic       flush_id,
  output logic       bubble_ex,
  output logic       pc_sel,
  output logic [7:0] branch_target,
  output logic       halted,
  output logic       mem_timeout,
  output logic [15:0] stall_count,
  output logic [1:0] state
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_LDSTALL = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_HALTED  = 2'd3;

  localparam logic [3:0] LD_RELOAD  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [7:0] TO_LIMIT   = 8'(MEM_TIMEOUT);
  localparam bit         LD_MULTI   = (LOAD_STALL_CYCLES > 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        halted_q, halted_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic stall_c, flush_c, flush_id_c, bubble_c, pc_sel_c;
  logic lu_hit;

  assign lu_hit = load_use & id_valid;

  // FSM next state and combinational pipe controls; reset forces every control low
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    flush_c    = 1'b0;
    flush_id_c = 1'b0;
    bubble_c   = 1'b0;
    pc_sel_c   = 1'b0;
    if (!reset_n) begin
      state_d = S_RUN;
      cnt_d   = 4'd0;
    end else if (state_q == S_HALTED) begin
      // Terminal state: only reset leaves, every input (mem_busy too) is ignored
      stall_c = 1'b1;
    end else if (mem_busy) begin
      // Freeze: EX is held and will re-present its events once memory is ready
      stall_c = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          if (ex_branch_taken) begin
            pc_sel_c   = 1'b1;
            flush_c    = 1'b1;
            flush_id_c = 1'b1;
          end else if (lu_hit) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (LD_MULTI) begin
              state_d = S_LDSTALL;
              cnt_d   = LD_RELOAD;
            end
          end else if (halt_fetched) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end
        end
        S_LDSTALL: begin
          // EX only holds bubbles here, so a branch indication is spurious
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (cnt_q == 4'd1) state_d = S_RUN;
          cnt_d = cnt_q - 4'd1;
        end
        S_DRAIN: begin
          if (ex_branch_taken) begin
            // An instruction older than HALT redirected: HALT was on the wrong path
            pc_sel_c   = 1'b1;
            flush_c    = 1'b1;
            flush_id_c = 1'b1;
            state_d    = S_RUN;
            cnt_d      = 4'd0;
          end else if (lu_hit) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            cnt_d    = DRAIN_LOAD;
          end else if (cnt_q == 4'd1) begin
            state_d = S_HALTED;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Debug counters: consecutive-busy timeout (saturating) and saturating stall-cycle count
  always_comb begin
    tcnt_d        = tcnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    halted_d      = (state_d == S_HALTED);
    if (state_q != S_HALTED) begin
      if (mem_busy) begin
        tcnt_d = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
        if (tcnt_d >= TO_LIMIT) mem_timeout_d = 1'b1;
      end else begin
        tcnt_d = 8'd0;
      end
    end
    if (stall_c && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      cnt_q         <= 4'd0;
      tcnt_q        <= 8'd0;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      halted_q      <= halted_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall         = stall_c;
  assign flush         = flush_c;
  assign flush_id      = flush_id_c;
  assign bubble_ex     = bubble_c;
  assign pc_sel        = pc_sel_c;
  assign branch_target = pc_sel_c ? ex_branch_target : 8'h00;
  assign halted        = halted_q;
  assign mem_timeout   = mem_timeout_q;
  assign stall_count   = stall_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed-vector bench for pipeline_controller with a queue-based scoreboard.
// Latency: each vector is driven 1ns after a rising edge and checked on the following falling edge.
// Backpressure: none; the monitor pops one expected record per cycle while the queue is non-empty.
module tb_pipeline_controller;

  logic        clk;
  logic        reset_n;
  logic        id_valid, load_use, ex_branch_taken, mem_busy, halt_fetched;
  logic [7:0]  ex_branch_target;
  logic        stall, flush, flush_id, bubble_ex, pc_sel, halted, mem_timeout;
  logic [7:0]  branch_target;
  logic [15:0] stall_count;
  logic [1:0]  state;

  typedef struct packed {
    logic       rst_n;
    logic       idv;
    logic       lu;
    logic       bt;
    logic [7:0] tgt;
    logic       mb;
    logic       hf;
  } in_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        flush_id;
    logic        bubble_ex;
    logic        pc_sel;
    logic [7:0]  branch_target;
    logic        halted;
    logic        mem_timeout;
    logic [15:0] stall_count;
    logic [1:0]  state;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    n_vec;
  int    n_bad;

  pipeline_controller #(
    .LOAD_STALL_CYCLES(2),
    .DRAIN_CYCLES(3),
    .MEM_TIMEOUT(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .id_valid(id_valid),
    .load_use(load_use),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .mem_busy(mem_busy),
    .halt_fetched(halt_fetched),
    .stall(stall),
    .flush(flush),
    .flush_id(flush_id),
    .bubble_ex(bubble_ex),
    .pc_sel(pc_sel),
    .branch_target(branch_target),
    .halted(halted),
    .mem_timeout(mem_timeout),
    .stall_count(stall_count),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t I(input logic r, input logic idv, input logic lu, input logic bt,
                            input logic [7:0] tgt, input logic mb, input logic hf);
    I = '{rst_n: r, idv: idv, lu: lu, bt: bt, tgt: tgt, mb: mb, hf: hf};
  endfunction

  // Expected: stall, flush, flush_id, bubble, pc_sel, target, halted, mem_timeout, stall_count, state
  function automatic out_t E(input logic s, input logic f, input logic fi, input logic b,
                             input logic p, input logic [7:0] t, input logic h, input logic mt,
                             input logic [15:0] sc, input logic [1:0] st);
    E = '{stall: s, flush: f, flush_id: fi, bubble_ex: b, pc_sel: p, branch_target: t,
          halted: h, mem_timeout: mt, stall_count: sc, state: st};
  endfunction

  task automatic vec(input string nm, input in_t i, input out_t e);
    @(posedge clk);
    #1;
    reset_n          = i.rst_n;
    id_valid         = i.idv;
    load_use         = i.lu;
    ex_branch_taken  = i.bt;
    ex_branch_target = i.tgt;
    mem_busy         = i.mb;
    halt_fetched     = i.hf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the full output bundle whenever an expected record is pending
  initial begin
    out_t  act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = '{stall: stall, flush: flush, flush_id: flush_id, bubble_ex: bubble_ex,
                pc_sel: pc_sel, branch_target: branch_target, halted: halted,
                mem_timeout: mem_timeout, stall_count: stall_count, state: state};
        n_vec++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got s/f/fi/b/p=%b%b%b%b%b tgt=%h h=%b mt=%b sc=%0d st=%0d, expected s/f/fi/b/p=%b%b%b%b%b tgt=%h h=%b mt=%b sc=%0d st=%0d",
                   nm, act.stall, act.flush, act.flush_id, act.bubble_ex, act.pc_sel,
                   act.branch_target, act.halted, act.mem_timeout, act.stall_count, act.state,
                   e.stall, e.flush, e.flush_id, e.bubble_ex, e.pc_sel,
                   e.branch_target, e.halted, e.mem_timeout, e.stall_count, e.state);
        end
      end
    end
  end

  initial begin
    int waited;
    n_vec = 0;
    n_bad = 0;
    reset_n = 1'b0; id_valid = 1'b0; load_use = 1'b0; ex_branch_taken = 1'b0;
    ex_branch_target = 8'h00; mem_busy = 1'b0; halt_fetched = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state; combinational outputs forced low even with a branch present
    vec("rst_hold",     I(0,0,0,1,8'h55,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd0));
    vec("idle",         I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd0));
    // Branch redirect in RUN
    vec("branch",       I(1,0,0,1,8'h40,0,0), E(0,1,1,0,1,8'h40,0,0,16'd0,2'd0));
    vec("branch_after", I(1,0,0,0,8'h40,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd0));
    // Load-use: two stall cycles, RUN -> LDSTALL -> RUN
    vec("lu_0",         I(1,1,1,0,8'h00,0,0), E(1,0,0,1,0,8'h00,0,0,16'd0,2'd0));
    vec("lu_1",         I(1,0,0,0,8'h00,0,0), E(1,0,0,1,0,8'h00,0,0,16'd1,2'd1));
    vec("lu_done",      I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd2,2'd0));
    vec("lu_no_idv",    I(1,0,1,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd2,2'd0));
    // Freeze for 4 cycles in the middle of LDSTALL (also 4 busy cycles: no timeout)
    vec("frz_lu_0",     I(1,1,1,0,8'h00,0,0), E(1,0,0,1,0,8'h00,0,0,16'd2,2'd0));
    vec("frz_1",        I(1,0,0,0,8'h00,1,0), E(1,0,0,0,0,8'h00,0,0,16'd3,2'd1));
    vec("frz_2",        I(1,0,0,0,8'h00,1,0), E(1,0,0,0,0,8'h00,0,0,16'd4,2'd1));
    vec("frz_3",        I(1,0,0,0,8'h00,1,0), E(1,0,0,0,0,8'h00,0,0,16'd5,2'd1));
    vec("frz_4",        I(1,0,0,0,8'h00,1,0), E(1,0,0,0,0,8'h00,0,0,16'd6,2'd1));
    vec("frz_resume",   I(1,0,0,0,8'h00,0,0), E(1,0,0,1,0,8'h00,0,0,16'd7,2'd1));
    vec("frz_done",     I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd8,2'd0));
    // Timeout: 5 consecutive busy cycles set the sticky flag; branch ignored while frozen
    vec("to_1",         I(1,0,0,0,8'h00,1,0), E(1,0,0,0,0,8'h00,0,0,16'd8,2'd0));
    vec("to_2_br",      I(1,0,0,1,8'h77,1,0), E(1,0,0,0,0,8'h00,0,0,16'd9,2'd0));
    vec("to_3",         I(1,0,0,0,8'h00,1,0), E(1,0,0,0,0,8'h00,0,0,16'd10,2'd0));
    vec("to_4",         I(1,1,1,0,8'h00,1,1), E(1,0,0,0,0,8'h00,0,0,16'd11,2'd0));
    vec("to_5",         I(1,0,0,0,8'h00,1,0), E(1,0,0,0,0,8'h00,0,0,16'd12,2'd0));
    vec("to_set",       I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,1,16'd13,2'd0));
    vec("to_sticky",    I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,1,16'd13,2'd0));
    // HALT then a branch from an older instruction cancels the drain
    vec("hb_halt",      I(1,0,0,0,8'h00,0,1), E(0,0,0,0,0,8'h00,0,1,16'd13,2'd0));
    vec("hb_drain",     I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,1,16'd13,2'd2));
    vec("hb_branch",    I(1,0,0,1,8'h9C,0,0), E(0,1,1,0,1,8'h9C,0,1,16'd13,2'd2));
    vec("hb_run",       I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,1,16'd13,2'd0));
    // HALT with a load-use inside DRAIN reloading the drain count, then HALTED
    vec("hl_halt",      I(1,0,0,0,8'h00,0,1), E(0,0,0,0,0,8'h00,0,1,16'd13,2'd0));
    vec("hl_d3",        I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,1,16'd13,2'd2));
    vec("hl_lu",        I(1,1,1,0,8'h00,0,0), E(1,0,0,1,0,8'h00,0,1,16'd13,2'd2));
    vec("hl_r3",        I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,1,16'd14,2'd2));
    vec("hl_r2",        I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,1,16'd14,2'd2));
    vec("hl_r1",        I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,1,16'd14,2'd2));
    vec("hl_halted_in", I(1,1,1,1,8'h33,1,1), E(1,0,0,0,0,8'h00,1,1,16'd14,2'd3));
    vec("hl_halted",    I(1,0,0,0,8'h00,0,0), E(1,0,0,0,0,8'h00,1,1,16'd15,2'd3));
    // Reset out of HALTED
    vec("hl_rst",       I(0,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,1,1,16'd16,2'd3));
    vec("hl_rst_done",  I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd0));
    // Reset mid-DRAIN with a load-use present: no residual stall
    vec("rd_halt",      I(1,0,0,0,8'h00,0,1), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd0));
    vec("rd_drain",     I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd2));
    vec("rd_rst",       I(0,1,1,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd2));
    vec("rd_run",       I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd0));
    // Plain HALT: three DRAIN cycles, then HALTED with stall held
    vec("ph_halt",      I(1,0,0,0,8'h00,0,1), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd0));
    vec("ph_d1",        I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd2));
    vec("ph_d2",        I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd2));
    vec("ph_d3",        I(1,0,0,0,8'h00,0,0), E(0,0,0,0,0,8'h00,0,0,16'd0,2'd2));
    vec("ph_halted",    I(1,0,0,0,8'h00,0,0), E(1,0,0,0,0,8'h00,1,0,16'd0,2'd3));
    vec("ph_halted2",   I(1,0,1,1,8'h12,0,0), E(1,0,0,0,0,8'h00,1,0,16'd1,2'd3));

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_queue: %0d expected records left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
